// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests instructions with a req/ready
// handshake, and holds the fetched PC/instruction pair for the IF/ID register.
module if_fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [15:0] PC_INC    = 16'd2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    input  logic        IMemReady,
    input  logic [15:0] IMemData,
    output logic        IMemReq,
    output logic [15:0] IMemAddr,
    output logic [15:0] OPC,
    output logic [15:0] OIR,
    output logic        Valid
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        REDIRECT
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] opc_q;
    logic [15:0] oir_q;
    logic        valid_q;

    logic        req_d;
    logic        fetch_done_d;
    logic [15:0] pc_next_d;
    logic [15:0] branch_pc_d;
    logic        unused_target_lsb;

    // A full output register under stall blocks new requests, so a late ready is ignored.
    always_comb begin
        req_d        = (state_q == FETCH) && !(valid_q && Stall);
        fetch_done_d = req_d && IMemReady;
        pc_next_d    = pc_q + PC_INC;
        branch_pc_d  = {BranchTarget[15:1], 1'b0};
    end

    assign unused_target_lsb = BranchTarget[0];

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            opc_q   <= '0;
            oir_q   <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (BranchTaken) begin
            // Redirect wins over any fetch completing or stall on this edge.
            state_q <= REDIRECT;
            pc_q    <= branch_pc_d;
            opc_q   <= '0;
            oir_q   <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                BOOT:     state_q <= FETCH;
                REDIRECT: state_q <= FETCH;
                default:  state_q <= FETCH;
            endcase
            if (fetch_done_d) begin
                opc_q   <= pc_q;
                oir_q   <= IMemData;
                valid_q <= 1'b1;
                pc_q    <= pc_next_d;
            end else if (valid_q && !Stall) begin
                oir_q   <= NOP_INSTR;
                valid_q <= 1'b0;
            end
        end
    end

    assign IMemReq  = req_d;
    assign IMemAddr = pc_q;
    assign OPC      = opc_q;
    assign OIR      = oir_q;
    assign Valid    = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: stimulus pushes expected PC/instruction
// pairs, a negedge monitor pops them as each new instruction is presented.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic        IMemReady;
    logic [15:0] IMemData;
    logic        IMemReq;
    logic [15:0] IMemAddr;
    logic [15:0] OPC;
    logic [15:0] OIR;
    logic        Valid;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    bit          fresh = 1'b1;

    always #5 CLK = ~CLK;

    if_fetch_stage #(
        .RESET_PC (16'h0000),
        .NOP_INSTR(16'h0000),
        .PC_INC   (16'd2)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .Stall       (Stall),
        .BranchTaken (BranchTaken),
        .BranchTarget(BranchTarget),
        .IMemReady   (IMemReady),
        .IMemData    (IMemData),
        .IMemReq     (IMemReq),
        .IMemAddr    (IMemAddr),
        .OPC         (OPC),
        .OIR         (OIR),
        .Valid       (Valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: a held instruction is new if the previous one was consumed or flushed.
    always @(negedge CLK) begin
        if (!Reset) begin
            fresh = 1'b1;
        end else begin
            if (Valid && fresh) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %h/%h expected none", OPC, OIR);
                end else begin
                    chk("sb_opc_oir", {OPC, OIR}, exp_q.pop_front());
                end
            end
            if (BranchTaken || (Valid && !Stall)) fresh = 1'b1;
            else if (Valid) fresh = 1'b0;
        end
    end

    initial begin
        #5000;
        n_vec++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
        IMemReady = 1'b0; IMemData = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_oir", 32'(OIR), 32'h0000);
        chk("rst_addr", 32'(IMemAddr), 32'h0000);
        chk("rst_req", 32'(IMemReq), 32'd0);

        // Release reset; first edge is BOOT, second captures 1111.
        tick();
        Reset = 1'b1; IMemReady = 1'b1; IMemData = 16'h1111;
        exp_q.push_back({16'h0000, 16'h1111});
        tick();
        @(negedge CLK);
        chk("boot_valid", 32'(Valid), 32'd0);
        chk("boot_req", 32'(IMemReq), 32'd1);
        tick();
        IMemData = 16'h2222;
        exp_q.push_back({16'h0002, 16'h2222});
        @(negedge CLK);
        chk("first_addr", 32'(IMemAddr), 32'h0002);

        // Stall for three cycles holding 0002/2222.
        tick();
        Stall = 1'b1; IMemData = 16'h3333;
        exp_q.push_back({16'h0004, 16'h3333});
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_req", 32'(IMemReq), 32'd0);
            chk("stall_hold", {OPC, OIR}, {16'h0002, 16'h2222});
            chk("stall_valid", 32'(Valid), 32'd1);
            tick();
        end
        Stall = 1'b0;
        tick();

        // Memory wait at PC 0006 for four edges.
        IMemReady = 1'b0;
        @(negedge CLK);
        chk("wait_addr", 32'(IMemAddr), 32'h0006);
        tick();
        @(negedge CLK);
        chk("wait_valid", 32'(Valid), 32'd0);
        chk("wait_oir", 32'(OIR), 32'h0000);
        chk("wait_req", 32'(IMemReq), 32'd1);
        chk("wait_addr2", 32'(IMemAddr), 32'h0006);
        repeat (3) tick();
        IMemReady = 1'b1; IMemData = 16'h4444;
        exp_q.push_back({16'h0006, 16'h4444});
        tick();

        // Branch on the same edge as a completing fetch of 5555.
        BranchTaken = 1'b1; BranchTarget = 16'h0101; IMemData = 16'h5555;
        @(negedge CLK);
        chk("pre_br_addr", 32'(IMemAddr), 32'h0008);
        tick();
        BranchTaken = 1'b0; IMemData = 16'h6666;
        exp_q.push_back({16'h0100, 16'h6666});
        @(negedge CLK);
        chk("redir_valid", 32'(Valid), 32'd0);
        chk("redir_req", 32'(IMemReq), 32'd0);
        chk("redir_addr", 32'(IMemAddr), 32'h0100);
        chk("redir_oir", 32'(OIR), 32'h0000);
        tick();
        @(negedge CLK);
        chk("post_redir_req", 32'(IMemReq), 32'd1);
        chk("post_redir_valid", 32'(Valid), 32'd0);
        tick();

        // Branch to FFFE, fetch 7777, PC wraps to 0000.
        BranchTaken = 1'b1; BranchTarget = 16'hFFFE;
        tick();
        BranchTaken = 1'b0; IMemData = 16'h7777;
        exp_q.push_back({16'hFFFE, 16'h7777});
        tick();
        tick();
        IMemReady = 1'b0;
        @(negedge CLK);
        chk("wrap_addr", 32'(IMemAddr), 32'h0000);
        chk("wrap_req", 32'(IMemReq), 32'd1);

        // Asynchronous reset while a request is outstanding.
        #1;
        Reset = 1'b0;
        #1;
        chk("async_valid", 32'(Valid), 32'd0);
        chk("async_addr", 32'(IMemAddr), 32'h0000);
        chk("async_req", 32'(IMemReq), 32'd0);
        chk("async_oir", 32'(OIR), 32'h0000);
        tick();
        Reset = 1'b1;
        repeat (2) tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
